// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, a, b,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, sub, a, b,
        output sum, cout, ovf, busy, done
    );

endinterface : serial_adder_if

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: purely combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic half;

    assign half  = a ^ b;
    assign sum   = half ^ cin;
    assign carry = (a & b) | (cin & half);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder.
// Latency: done pulses WIDTH cycles after the edge that accepts start.
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                end
            end

            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = DONE;
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    serial_adder_if #(.WIDTH(8)) bus ();

    serial_adder #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation, scrambles the operand inputs after acceptance,
    // then checks latency, result flags and hold-after-done.
    task automatic run_op(input string tag, input logic s, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] es,
                          input logic ec, input logic eo);
        int cyc;
        bit seen;
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        bus.sub   = ~s;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd8);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        tick();
        chk({tag, "_done_lo"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hold"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        int ndone;
        int dcyc;
        int d1;
        int d2;
        int w;

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) tick();
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);

        rst   = 1'b0;
        bus.a = 8'hFF;
        bus.b = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nostart_sum", 32'(bus.sum), 32'd0);
            chk("nostart_busy", 32'(bus.busy), 32'd0);
            chk("nostart_done", 32'(bus.done), 32'd0);
        end

        run_op("add",   1'b0, 8'd100, 8'd27,  8'd127, 1'b0, 1'b0);
        run_op("ovfp",  1'b0, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b1);
        run_op("wrap",  1'b0, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b0);
        run_op("subb",  1'b1, 8'd5,   8'd9,   8'hFC,  1'b0, 1'b0);
        run_op("subov", 1'b1, 8'h80,  8'h01,  8'h7F,  1'b1, 1'b1);
        run_op("subz",  1'b1, 8'h0A,  8'h0A,  8'h00,  1'b1, 1'b0);

        // Second start during RUN must be dropped.
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 8'd100;
        bus.b     = 8'd27;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        dcyc  = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'd1;
                bus.b     = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.done) begin
                ndone++;
                dcyc = c;
                chk("ign_sum", 32'(bus.sum), 32'd127);
            end
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_lat", 32'(dcyc), 32'd8);
        chk("ign_idle", 32'(bus.busy), 32'd0);

        // Held start: back-to-back operations 10 cycles apart.
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 8'd3;
        bus.b     = 8'd4;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus.done) begin
                chk("held_sum", 32'(bus.sum), 32'd7);
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        bus.start = 1'b0;
        chk("held_first", 32'(d1), 32'd9);
        chk("held_gap", 32'(d2 - d1), 32'd10);
        w = 0;
        while (bus.busy && w < 20) begin
            tick();
            w++;
        end
        chk("held_drain", 32'(bus.busy), 32'd0);

        // Leave cout/ovf set so the abort clearing them is visible.
        run_op("negov", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 8'h55;
        bus.b     = 8'h22;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.done || bus.busy) ndone++;
        end
        chk("abort_quiet", 32'(ndone), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_op("post", 1'b0, 8'h55, 8'h22, 8'h77, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; the block has one clock, and reset is synchronous and active-high.
REQ-004 Port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port sub  input  1  mode at start: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 Port a  input  WIDTH  operand A; sampled with start.
REQ-007 Port b  input  WIDTH  operand B; sampled with start.
REQ-008 Port sum  output  WIDTH  result; valid while done=1, held afterward until next accepted start.
REQ-009 Port cout  output  1  final carry out of MSB; in sub mode 1 = no borrow.
REQ-010 Port ovf  output  1  signed two's-complement overflow flag of the result.
REQ-011 Port busy  output  1  high in RUN and DONE states.
REQ-012 Port done  output  1  single-cycle pulse, high only in DONE state.

Function
REQ-013 Block SHALL compute the result bit-serially, LSB first, one bit per clock, through a single 1-bit full-adder cell plus a carry register.
REQ-014 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally after one cycle.
REQ-015 On accepted start SHALL load shift registers with a and (sub ? ~b : b), set carry to sub, clear bit counter.
REQ-016 Each RUN cycle SHALL shift one result bit into sum MSB-side shift register, update carry, increment counter; counter width SHALL be clog2(WIDTH+1).
REQ-017 Latency: done SHALL be high exactly WIDTH cycles after the clock edge that accepted start.
REQ-018 cout SHALL equal carry after MSB; ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB; both valid with done.
REQ-019 start asserted in RUN or DONE SHALL be ignored (no restart, no queueing); a, b, sub changes after acceptance SHALL not affect the result.
REQ-020 start held continuously SHALL yield back-to-back operations with exactly one IDLE cycle between done and the next accept.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; wrap-around reflected only in cout/ovf.
REQ-022 sum, cout, ovf SHALL hold their last values in IDLE until the next accepted start begins overwriting them.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, counter and carry cleared.
REQ-024 rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; start in the same cycle as rst SHALL be ignored.
REQ-025 First start SHALL be accepted at the first edge after rst deasserts.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the FSM state type (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The 1-bit add cell SHALL be the team's existing full_adder module (a, b, cin, sum, carry) instantiated once; no other sub-modules.

Verification (WIDTH=8)
REQ-028 Reset: hold rst 2 cycles, then a=8'hFF,b=8'h01 without start -> sum=0, busy=0, done=0 throughout.
REQ-029 Add: start,sub=0,a=8'd100,b=8'd27 -> done exactly 8 cycles after accept, sum=8'd127, cout=0, ovf=0.
REQ-030 Wrap/overflow: a=8'h7F,b=8'h01,sub=0 -> sum=8'h80, cout=0, ovf=1; a=8'hFF,b=8'h01 -> sum=8'h00, cout=1, ovf=0.
REQ-031 Subtract: a=8'd5,b=8'd9,sub=1 -> sum=8'hFC, cout=0 (borrow), ovf=0; a=8'h80,b=8'h01,sub=1 -> sum=8'h7F, ovf=1.
REQ-032 Busy protocol: second start with different operands on cycle 3 of RUN -> ignored, first result unchanged, single done pulse; start held high -> done pulses spaced 10 cycles apart.
REQ-033 Abort: rst at cycle 4 of RUN -> IDLE next cycle, no done, outputs zero; new start afterward completes correctly.
